pwd_unlock_ctrl: RTL and testbench

//  Password sequencer in front of the protected register-file memory. Collects key digits

---
 rtl/pwd_unlock_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pwd_unlock_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwd_unlock_ctrl.sv
// Password sequencer guarding the protected register-file memory.
// Collects key digits, checks them against the stored password, and grants
// memory access through o_unlock. Adds lockout after repeated failures, idle
// auto-relock, and password change while unlocked.
module pwd_unlock_ctrl #(
  parameter int unsigned PW_LEN   = 4,
  parameter int unsigned DIGIT_W  = 4,
  parameter int unsigned MAX_FAIL = 3,
  parameter int unsigned LOCK_CYC = 50_000_000,
  parameter int unsigned IDLE_CYC = 500_000_000,
  parameter logic [PW_LEN*DIGIT_W-1:0] PW_INIT = 16'h1234
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIGIT_W-1:0]            key_in,
  input  logic                          en_key,
  input  logic                          access,
  input  logic                          relock,
  input  logic                          chg_pw,
  output logic                          o_unlock,
  output logic                          o_lockout,
  output logic                          o_chg_mode,
  output logic [$clog2(MAX_FAIL+1)-1:0] o_fail_cnt,
  output logic [$clog2(PW_LEN+1)-1:0]   o_digit_cnt
);

  localparam int unsigned PW_W   = PW_LEN * DIGIT_W;
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int unsigned DCNT_W = $clog2(PW_LEN + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_CYC + 1);
  localparam int unsigned IDLE_W = $clog2(IDLE_CYC + 1);

  localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(PW_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST  = FAIL_W'(MAX_FAIL - 1);
  localparam logic [FAIL_W-1:0] FAIL_FULL  = FAIL_W'(MAX_FAIL);
  localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCK_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_UNLOCKED,
    S_NEWPW,
    S_LOCKOUT
  } state_t;

  state_t              state, state_n;
  logic [PW_W-1:0]     entry, entry_n;
  logic [PW_W-1:0]     pw, pw_n;
  logic [DCNT_W-1:0]   digit_cnt, digit_cnt_n;
  logic [FAIL_W-1:0]   fail_cnt, fail_cnt_n;
  logic [LOCK_W-1:0]   lock_tmr, lock_tmr_n;
  logic [IDLE_W-1:0]   idle_tmr, idle_tmr_n;
  logic [PW_W-1:0]     entry_shift;
  logic                last_digit;

  // Entry register with the strobed digit appended in the LSBs
  always_comb begin
    entry_shift = (entry << DIGIT_W) | PW_W'(key_in);
    last_digit  = (digit_cnt == DCNT_LAST);
  end

  // Next-state and next-value logic for the sequencer
  always_comb begin
    state_n     = state;
    entry_n     = entry;
    pw_n        = pw;
    digit_cnt_n = digit_cnt;
    fail_cnt_n  = fail_cnt;
    lock_tmr_n  = lock_tmr;
    idle_tmr_n  = idle_tmr;

    unique case (state)
      S_IDLE: begin
        if (relock) begin
          entry_n     = '0;
          digit_cnt_n = '0;
        end else if (en_key) begin
          entry_n = entry_shift;
          if (last_digit) begin
            digit_cnt_n = '0;
            state_n     = S_CHECK;
          end else begin
            digit_cnt_n = digit_cnt + DCNT_W'(1);
          end
        end
      end

      S_CHECK: begin
        entry_n = '0;
        if (entry == pw) begin
          fail_cnt_n = '0;
          idle_tmr_n = '0;
          state_n    = S_UNLOCKED;
        end else if (fail_cnt == FAIL_LAST) begin
          fail_cnt_n = FAIL_FULL;
          lock_tmr_n = '0;
          state_n    = S_LOCKOUT;
        end else begin
          fail_cnt_n = fail_cnt + FAIL_W'(1);
          state_n    = S_IDLE;
        end
      end

      S_UNLOCKED: begin
        if (access) begin
          idle_tmr_n = '0;
        end else if (idle_tmr != IDLE_LAST) begin
          idle_tmr_n = idle_tmr + IDLE_W'(1);
        end
        if (relock) begin
          state_n = S_IDLE;
        end else if (chg_pw) begin
          entry_n     = '0;
          digit_cnt_n = '0;
          state_n     = S_NEWPW;
        end else if (!access && idle_tmr == IDLE_LAST) begin
          state_n = S_IDLE;
        end
      end

      S_NEWPW: begin
        if (relock) begin
          entry_n     = '0;
          digit_cnt_n = '0;
          state_n     = S_IDLE;
        end else if (en_key) begin
          if (last_digit) begin
            pw_n        = entry_shift;
            entry_n     = '0;
            digit_cnt_n = '0;
            idle_tmr_n  = '0;
            state_n     = S_UNLOCKED;
          end else begin
            entry_n     = entry_shift;
            digit_cnt_n = digit_cnt + DCNT_W'(1);
          end
        end
      end

      S_LOCKOUT: begin
        if (lock_tmr == LOCK_LAST) begin
          fail_cnt_n = '0;
          state_n    = S_IDLE;
        end else begin
          lock_tmr_n = lock_tmr + LOCK_W'(1);
        end
      end

      default: begin
        entry_n     = '0;
        digit_cnt_n = '0;
        state_n     = S_IDLE;
      end
    endcase
  end

  // State, datapath registers and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      entry      <= '0;
      pw         <= PW_INIT;
      digit_cnt  <= '0;
      fail_cnt   <= '0;
      lock_tmr   <= '0;
      idle_tmr   <= '0;
      o_unlock   <= 1'b0;
      o_lockout  <= 1'b0;
      o_chg_mode <= 1'b0;
    end else begin
      state      <= state_n;
      entry      <= entry_n;
      pw         <= pw_n;
      digit_cnt  <= digit_cnt_n;
      fail_cnt   <= fail_cnt_n;
      lock_tmr   <= lock_tmr_n;
      idle_tmr   <= idle_tmr_n;
      o_unlock   <= (state_n == S_UNLOCKED);
      o_lockout  <= (state_n == S_LOCKOUT);
      o_chg_mode <= (state_n == S_NEWPW);
    end
  end

  // Counters are registers already; expose them directly
  always_comb begin
    o_fail_cnt  = fail_cnt;
    o_digit_cnt = digit_cnt;
  end

endmodule

// File: tb/tb_pwd_unlock_ctrl.sv
// Bench for pwd_unlock_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the unlock rules.
module tb_pwd_unlock_ctrl;

  localparam int LOCK_N = 8;
  localparam int IDLE_N = 10;
  localparam int MAXF   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic       en_key, access, relock, chg_pw;
  logic       o_unlock, o_lockout, o_chg_mode;
  logic [1:0] o_fail_cnt;
  logic [2:0] o_digit_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pwd_unlock_ctrl #(
    .PW_LEN(4), .DIGIT_W(4), .MAX_FAIL(MAXF),
    .LOCK_CYC(LOCK_N), .IDLE_CYC(IDLE_N), .PW_INIT(16'h1234)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .en_key(en_key),
    .access(access), .relock(relock), .chg_pw(chg_pw),
    .o_unlock(o_unlock), .o_lockout(o_lockout), .o_chg_mode(o_chg_mode),
    .o_fail_cnt(o_fail_cnt), .o_digit_cnt(o_digit_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: modes, digits typed so far, stored code, countdowns
  localparam int M_LOCKED = 0, M_CHECK = 1, M_OPEN = 2, M_NEW = 3, M_BLOCKED = 4;
  int m_mode, m_cnt, m_val, m_attempt, m_pw, m_fails, m_quiet, m_left;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_LOCKED; m_cnt = 0; m_val = 0; m_attempt = 0;
    m_pw = 'h1234; m_fails = 0; m_quiet = 0; m_left = 0;
  endtask

  task automatic model_step(input logic e, input int k, input logic a, input logic rl, input logic cp);
    case (m_mode)
      M_LOCKED: begin
        if (rl) begin
          m_cnt = 0; m_val = 0;
        end else if (e) begin
          m_val = (m_val * 16 + k) % 65536;
          m_cnt++;
          if (m_cnt == 4) begin
            m_attempt = m_val; m_cnt = 0; m_val = 0; m_mode = M_CHECK;
          end
        end
      end
      M_CHECK: begin
        if (m_attempt == m_pw) begin
          m_mode = M_OPEN; m_fails = 0; m_quiet = 0;
        end else if (m_fails + 1 == MAXF) begin
          m_mode = M_BLOCKED; m_fails = MAXF; m_left = LOCK_N;
        end else begin
          m_fails++; m_mode = M_LOCKED;
        end
      end
      M_OPEN: begin
        if (rl) m_mode = M_LOCKED;
        else if (cp) begin
          m_mode = M_NEW; m_cnt = 0; m_val = 0;
        end else if (a) m_quiet = 0;
        else if (m_quiet == IDLE_N - 1) m_mode = M_LOCKED;
        else m_quiet++;
      end
      M_NEW: begin
        if (rl) begin
          m_mode = M_LOCKED; m_cnt = 0; m_val = 0;
        end else if (e) begin
          m_val = (m_val * 16 + k) % 65536;
          m_cnt++;
          if (m_cnt == 4) begin
            m_pw = m_val; m_cnt = 0; m_val = 0; m_mode = M_OPEN; m_quiet = 0;
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = M_LOCKED; m_fails = 0;
        end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_unlock"},  32'(o_unlock),    32'(m_mode == M_OPEN));
    check_eq({tag, "_lockout"}, 32'(o_lockout),   32'(m_mode == M_BLOCKED));
    check_eq({tag, "_chgmode"}, 32'(o_chg_mode),  32'(m_mode == M_NEW));
    check_eq({tag, "_failcnt"}, 32'(o_fail_cnt),  32'(m_fails));
    check_eq({tag, "_digcnt"},  32'(o_digit_cnt), 32'(m_cnt));
  endtask

  // One clock: drive inputs, clock the model alongside the DUT, compare
  task automatic step(input logic e, input logic [3:0] k, input logic a, input logic rl, input logic cp);
    en_key = e; key_in = k; access = a; relock = rl; chg_pw = cp;
    @(posedge clk);
    model_step(e, int'(k), a, rl, cp);
    #1;
    check_model("cyc");
    en_key = 1'b0; access = 1'b0; relock = 1'b0; chg_pw = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter(input logic [15:0] code);
    for (int i = 0; i < 4; i++) step(1'b1, code[15-4*i -: 4], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    en_key = 1'b0; access = 1'b0; relock = 1'b0; chg_pw = 1'b0; key_in = 4'h0;
    rst = 1'b1;
    #2;
    model_reset();
    check_model("rst");
    #2 rst = 1'b0;
  endtask

  int hi;
  int pick;
  logic [3:0] kd;

  initial begin
    rst = 1'b1; key_in = 4'h0; en_key = 1'b0; access = 1'b0; relock = 1'b0; chg_pw = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model("reset");
    rst = 1'b0;

    // Correct code: CHECK cycle keeps unlock low, then it rises
    enter(16'h1234);
    check_eq("s1_in_check", 32'(o_unlock), 32'd0);
    idle(1);
    check_eq("s1_unlocked", 32'(o_unlock), 32'd1);
    check_eq("s1_failcnt", 32'(o_fail_cnt), 32'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Three wrong codes lead to lockout of LOCK_N cycles
    enter(16'h1235); idle(1);
    enter(16'h1235); idle(1);
    check_eq("s2_failcnt2", 32'(o_fail_cnt), 32'd2);
    check_eq("s2_locked", 32'(o_unlock), 32'd0);
    enter(16'h1235); idle(1);
    check_eq("s2_lockout_on", 32'(o_lockout), 32'd1);
    hi = 1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 4'($urandom), 1'b0, 1'b1, 1'b1);
      hi += int'(o_lockout);
    end
    check_eq("s2_lockout_len", 32'(hi), 32'(LOCK_N));
    check_eq("s2_fail_clr", 32'(o_fail_cnt), 32'd0);
    enter(16'h1234); idle(1);
    check_eq("s2_unlock", 32'(o_unlock), 32'd1);

    // Idle timeout with and without an access in the last cycle
    hi = int'(o_unlock);
    for (int i = 0; i < 12; i++) begin
      idle(1);
      hi += int'(o_unlock);
    end
    check_eq("s3_timeout", 32'(hi), 32'(IDLE_N));
    enter(16'h1234); idle(1);
    idle(IDLE_N - 1);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    hi = int'(o_unlock);
    for (int i = 0; i < 12; i++) begin
      idle(1);
      hi += int'(o_unlock);
    end
    check_eq("s3_access_extend", 32'(hi), 32'(IDLE_N));

    // Password change to ABCD
    enter(16'h1234); idle(1);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    check_eq("s4_newpw_unlock", 32'(o_unlock), 32'd0);
    check_eq("s4_newpw_mode", 32'(o_chg_mode), 32'd1);
    enter(16'hABCD);
    check_eq("s4_back_unlock", 32'(o_unlock), 32'd1);
    check_eq("s4_back_mode", 32'(o_chg_mode), 32'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    enter(16'h1234); idle(1);
    check_eq("s4_old_rejected", 32'(o_unlock), 32'd0);
    check_eq("s4_old_failcnt", 32'(o_fail_cnt), 32'd1);
    enter(16'hABCD); idle(1);
    check_eq("s4_new_accepted", 32'(o_unlock), 32'd1);

    // Relock priority and aborted password change
    do_reset();
    enter(16'h1234); idle(1);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    check_eq("s5_relock_wins", 32'(o_unlock), 32'd0);
    check_eq("s5_no_chgmode", 32'(o_chg_mode), 32'd0);
    enter(16'h1234); idle(1);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    check_eq("s5_two_digits", 32'(o_digit_cnt), 32'd2);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    check_eq("s5_abort_mode", 32'(o_chg_mode), 32'd0);
    check_eq("s5_abort_digits", 32'(o_digit_cnt), 32'd0);
    enter(16'h1234); idle(1);
    check_eq("s5_pw_kept", 32'(o_unlock), 32'd1);

    // Asynchronous reset in the middle of a password change
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    check_eq("s6_in_newpw", 32'(o_chg_mode), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("s6_async_unlock", 32'(o_unlock), 32'd0);
    check_eq("s6_async_chgmode", 32'(o_chg_mode), 32'd0);
    check_eq("s6_async_digits", 32'(o_digit_cnt), 32'd0);
    model_reset();
    #2 rst = 1'b0;
    enter(16'h1234); idle(1);
    check_eq("s6_pw_restored", 32'(o_unlock), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      pick = int'($urandom_range(999));
      if (pick < 3) begin
        do_reset();
      end else begin
        if ($urandom_range(99) < 60 && m_cnt < 4)
          kd = 4'((m_pw >> (4 * (3 - m_cnt))) & 15);
        else
          kd = 4'($urandom);
        step($urandom_range(99) < 45, kd, $urandom_range(99) < 20,
             $urandom_range(99) < 3, $urandom_range(99) < 6);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
